// File: rtl/filter_fetch_ctrl.sv
// Filter RAM sequencer: streams FILTER_SIZE weights of one filter, arbitrates host writes while idle.
// Optional FILTER_FETCH_STALL_CNT_EN adds a saturating stall_count output.
module filter_fetch_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 576,
    parameter int FILTER_SIZE = 9,
    parameter int NUM_FILTERS = 64,
    parameter int IDX_W       = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  filter_index,
    output logic              busy,
    output logic              done,
    output logic              idx_err,
    input  logic              host_wr_req,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ack,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_enable,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [DATA_W-1:0] weight_data,
    output logic              weight_valid,
    output logic              weight_last,
    input  logic              weight_ready
`ifdef FILTER_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int          CNT_W = $clog2(FILTER_SIZE + 1);
    localparam logic [31:0] NUM_F_U = NUM_FILTERS;
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wvalid_q, wvalid_d;
    logic               wlast_q, wlast_d;

    logic [IDX_W-1:0]   idx_sel;
    logic               idx_ok;
    logic               addr_ok;
    logic               out_free;
    logic               cnt_last;
    logic               start_acc;

    // A start arriving this cycle takes precedence over an older pending index.
    assign idx_sel   = start ? filter_index : idx_q;
    assign idx_ok    = 32'(idx_sel) < NUM_F_U;
    assign addr_ok   = 32'(host_wr_addr) < DEPTH_U;
    assign out_free  = !wvalid_q || weight_ready;
    assign cnt_last  = (cnt_q == CNT_W'(FILTER_SIZE - 1));
    assign start_acc = (state_q == IDLE) && start;

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        idx_d          = idx_q;
        base_d         = base_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        wdata_d        = wdata_q;
        wvalid_d       = wvalid_q;
        wlast_d        = wlast_q;
        host_wr_ack    = 1'b0;
        ram_enable     = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_write_data = '0;
        unique case (state_q)
            IDLE: begin
                host_wr_ack = host_wr_req;
                if (host_wr_req) begin
                    ram_address    = host_wr_addr;
                    ram_write_data = host_wr_data;
                    ram_enable     = addr_ok;
                    ram_write      = addr_ok;
                end
                if (start) begin
                    pend_d = 1'b1;
                    idx_d  = filter_index;
                end
                if ((pend_q || start) && !host_wr_req) begin
                    pend_d = 1'b0;
                    if (!idx_ok) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        base_d  = ADDR_W'(idx_sel) * ADDR_W'(FILTER_SIZE);
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                ram_enable  = 1'b1;
                ram_address = base_q + ADDR_W'(cnt_q);
                if (out_free) begin
                    wdata_d  = ram_read_data;
                    wvalid_d = 1'b1;
                    wlast_d  = cnt_last;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (weight_ready) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    state_d  = FIN;
                end
            end
            FIN: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            idx_q    <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign idx_err      = (state_q == FIN) && err_q;
    assign weight_data  = wdata_q;
    assign weight_valid = wvalid_q;
    assign weight_last  = wlast_q;

`ifdef FILTER_FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (wvalid_q && !weight_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_filter_fetch_ctrl.sv
// Directed bench for filter_fetch_ctrl with a behavioural 16-bit RAM; second instance uses 7-bit index.
module tb_filter_fetch_ctrl;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  filter_index;
    logic        busy, done, idx_err;
    logic        host_wr_req;
    logic [9:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        host_wr_ack;
    logic [9:0]  ram_address;
    logic [15:0] ram_write_data;
    logic        ram_enable, ram_write;
    logic [15:0] ram_read_data;
    logic [15:0] weight_data;
    logic        weight_valid, weight_last, weight_ready;

    logic        e_start;
    logic [6:0]  e_index;
    logic        e_busy, e_done, e_idx_err, e_ack;
    logic [9:0]  e_addr;
    logic [15:0] e_wdata, e_data;
    logic        e_en, e_wr, e_valid, e_last;
    logic        e_req = 1'b0;
    logic [9:0]  e_haddr = '0;
    logic [15:0] e_hdata = '0;
    logic [15:0] e_rdata = '0;
    logic        e_ready = 1'b1;
`ifdef FILTER_FETCH_STALL_CNT_EN
    logic [15:0] stall_count, e_stall_count;
`endif

    logic [15:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock)
        if (ram_enable && ram_write) mem[ram_address] <= ram_write_data;
    assign ram_read_data = mem[ram_address];

    filter_fetch_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start), .filter_index(filter_index),
        .busy(busy), .done(done), .idx_err(idx_err),
        .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_ack(host_wr_ack), .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_enable(ram_enable), .ram_write(ram_write), .ram_read_data(ram_read_data),
        .weight_data(weight_data), .weight_valid(weight_valid), .weight_last(weight_last),
        .weight_ready(weight_ready)
`ifdef FILTER_FETCH_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    filter_fetch_ctrl #(.IDX_W(7)) dut_err (
        .clock(clock), .reset_n(reset_n), .start(e_start), .filter_index(e_index),
        .busy(e_busy), .done(e_done), .idx_err(e_idx_err),
        .host_wr_req(e_req), .host_wr_addr(e_haddr), .host_wr_data(e_hdata),
        .host_wr_ack(e_ack), .ram_address(e_addr), .ram_write_data(e_wdata),
        .ram_enable(e_en), .ram_write(e_wr), .ram_read_data(e_rdata),
        .weight_data(e_data), .weight_valid(e_valid), .weight_last(e_last),
        .weight_ready(e_ready)
`ifdef FILTER_FETCH_STALL_CNT_EN
        , .stall_count(e_stall_count)
`endif
    );

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 0; filter_index = 0; host_wr_req = 0;
        host_wr_addr = 0; host_wr_data = 0; weight_ready = 1; e_start = 0; e_index = 0;
        step; step; #1;
        checks++;
        if ({busy, done, idx_err, weight_valid, weight_last, ram_enable, ram_write, host_wr_ack} !== 8'h00
            || weight_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got flags %b data %h, want 0 and 0",
                {busy, done, idx_err, weight_valid, weight_last, ram_enable, ram_write, host_wr_ack}, weight_data);
        end
        step; reset_n = 1'b1; #1;
        checks++;
        if (busy !== 1'b0 || e_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b/%b want 0/0", busy, e_busy);
        end
    endtask

    task automatic test_preload;
        int bad = 0;
        for (int a = 0; a < 576; a++) begin
            step; host_wr_req = 1; host_wr_addr = 10'(a); host_wr_data = 16'(a); #1;
            if (host_wr_ack !== 1'b1 || ram_enable !== 1'b1 || ram_write !== 1'b1 || ram_address !== 10'(a))
                bad++;
        end
        step; host_wr_req = 0; #1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL preload_ack: got %0d bad write cycles want 0", bad);
        end
        checks++;
        if (mem[0] !== 16'd0 || mem[575] !== 16'd575) begin
            errors++; $display("FAIL preload_commit: got %h/%h want 0000/023f", mem[0], mem[575]);
        end
    endtask

    task automatic test_fetch0;
        step; start = 1; filter_index = 0; weight_ready = 1; #1;
        step; start = 0; #1;
        checks++;
        if (busy !== 1 || weight_valid !== 0 || ram_enable !== 1 || ram_write !== 0 || ram_address !== 10'd0) begin
            errors++; $display("FAIL fetch0_first_cycle: got busy %b v %b en %b wr %b addr %0d want 1 0 1 0 0",
                busy, weight_valid, ram_enable, ram_write, ram_address);
        end
        for (int c = 1; c <= 11; c++) begin
            step; #1;
            checks++;
            if (weight_valid !== (c <= 9) || done !== (c == 10) || idx_err !== 0) begin
                errors++; $display("FAIL fetch0_cycle%0d: got v %b done %b err %b want %b %b 0",
                    c, weight_valid, done, idx_err, c <= 9, c == 10);
            end
            if (c <= 9) begin
                checks++;
                if (weight_data !== 16'(c - 1) || weight_last !== (c == 9)) begin
                    errors++; $display("FAIL fetch0_beat%0d: got %h last %b want %h last %b",
                        c - 1, weight_data, weight_last, 16'(c - 1), c == 9);
                end
            end
        end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL fetch0_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_stall63;
        int nb = 0;
        bit seen_done = 0;
        logic pv = 0, pr = 0;
        logic [15:0] pd = 0;
        step; start = 1; filter_index = 63; weight_ready = 0; #1;
        step; start = 0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (c > 0) step;
            weight_ready = c[0]; #1;
            if (pv && !pr) begin
                checks++;
                if (weight_valid !== 1 || weight_data !== pd) begin
                    errors++; $display("FAIL stall_hold: got v %b %h want 1 %h", weight_valid, weight_data, pd);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                checks++;
                if (nb != 9) begin errors++; $display("FAIL stall_beats: got %0d want 9", nb); end
            end
            if (weight_valid === 1'b1 && weight_ready) begin
                checks++;
                if (weight_data !== 16'(567 + nb) || weight_last !== (nb == 8)) begin
                    errors++; $display("FAIL stall_beat%0d: got %h last %b want %h last %b",
                        nb, weight_data, weight_last, 16'(567 + nb), nb == 8);
                end
                nb++;
            end
            pv = weight_valid; pr = weight_ready; pd = weight_data;
        end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL stall_timeout: got no done want done"); end
`ifdef FILTER_FETCH_STALL_CNT_EN
        checks++;
        if (stall_count !== 16'd8) begin
            errors++; $display("FAIL stall_count: got %0d want 8", stall_count);
        end
`endif
        weight_ready = 1;
    endtask

    task automatic test_idx_err;
        step; e_start = 1; e_index = 7'd64; #1;
        checks++;
        if (e_en !== 0 || e_busy !== 0) begin
            errors++; $display("FAIL err_accept: got en %b busy %b want 0 0", e_en, e_busy);
        end
        step; e_start = 0; #1;
        checks++;
        if (e_done !== 1 || e_idx_err !== 1 || e_valid !== 0 || e_en !== 0) begin
            errors++; $display("FAIL err_pulse: got done %b err %b v %b en %b want 1 1 0 0",
                e_done, e_idx_err, e_valid, e_en);
        end
        step; #1;
        checks++;
        if (e_done !== 0 || e_idx_err !== 0 || e_busy !== 0 || e_en !== 0) begin
            errors++; $display("FAIL err_after: got done %b err %b busy %b en %b want 0 0 0 0",
                e_done, e_idx_err, e_busy, e_en);
        end
    endtask

    task automatic test_host_during_fetch;
        bit acked = 0, seen_done = 0;
        int bad = 0;
        step; start = 1; filter_index = 0; weight_ready = 1; #1;
        step; start = 0; host_wr_req = 1; host_wr_addr = 10'd9; host_wr_data = 16'h0ABC; #1;
        for (int c = 0; c < 20 && !acked; c++) begin
            if (c > 0) begin step; #1; end
            if (done === 1'b1) seen_done = 1;
            if (busy === 1'b1) begin
                if (host_wr_ack !== 0 || ram_write !== 0) bad++;
            end else begin
                acked = 1;
                checks++;
                if (host_wr_ack !== 1 || !seen_done || ram_enable !== 1 || ram_write !== 1) begin
                    errors++; $display("FAIL host_after_done: got ack %b done_seen %b en %b wr %b want 1 1 1 1",
                        host_wr_ack, seen_done, ram_enable, ram_write);
                end
            end
        end
        checks++;
        if (bad != 0 || !acked) begin
            errors++; $display("FAIL host_blocked: got %0d acked-while-busy, acked %b want 0, 1", bad, acked);
        end
        step; host_wr_req = 0; #1;
        checks++;
        if (mem[9] !== 16'h0ABC) begin errors++; $display("FAIL host_commit: got %h want 0abc", mem[9]); end
        step; start = 1; filter_index = 1; #1;
        step; start = 0; #1;
        step; #1;
        checks++;
        if (weight_valid !== 1 || weight_data !== 16'h0ABC) begin
            errors++; $display("FAIL host_fetch1_w0: got v %b %h want 1 0abc", weight_valid, weight_data);
        end
        step; #1;
        checks++;
        if (weight_data !== 16'd10) begin errors++; $display("FAIL host_fetch1_w1: got %h want 000a", weight_data); end
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin step; #1; end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL host_fetch1_timeout: got busy %b want 0", busy); end
    endtask

    task automatic test_bad_addr_simul;
        mem[600] = 16'h5555;
        step; host_wr_req = 1; host_wr_addr = 10'd600; host_wr_data = 16'h1234; #1;
        checks++;
        if (host_wr_ack !== 1 || ram_enable !== 0) begin
            errors++; $display("FAIL bad_addr: got ack %b en %b want 1 0", host_wr_ack, ram_enable);
        end
        step; host_wr_addr = 10'd20; host_wr_data = 16'h1111; start = 1; filter_index = 2; #1;
        checks++;
        if (host_wr_ack !== 1 || ram_enable !== 1 || busy !== 0) begin
            errors++; $display("FAIL simul_ack: got ack %b en %b busy %b want 1 1 0", host_wr_ack, ram_enable, busy);
        end
        step; host_wr_req = 0; start = 0; #1;
        checks++;
        if (mem[600] !== 16'h5555 || mem[20] !== 16'h1111 || busy !== 0) begin
            errors++; $display("FAIL simul_commit: got m600 %h m20 %h busy %b want 5555 1111 0", mem[600], mem[20], busy);
        end
        step; #1;
        checks++;
        if (busy !== 1 || ram_address !== 10'd18 || weight_valid !== 0) begin
            errors++; $display("FAIL simul_fetch: got busy %b addr %0d v %b want 1 18 0", busy, ram_address, weight_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step; #1;
            checks++;
            if (weight_valid !== 1 || weight_data !== ((k == 2) ? 16'h1111 : 16'(18 + k))) begin
                errors++; $display("FAIL simul_beat%0d: got v %b %h want 1 %h", k, weight_valid, weight_data,
                    (k == 2) ? 16'h1111 : 16'(18 + k));
            end
        end
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin step; #1; end
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL simul_timeout: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        bit seen_done = 0;
        step; start = 1; filter_index = 3; weight_ready = 1; #1;
        step; start = 0;
        for (int k = 0; k < 4; k++) step;
        #1;
        checks++;
        if (weight_data !== 16'd30) begin errors++; $display("FAIL mid_4th: got %h want 001e", weight_data); end
        reset_n = 0; #1;
        checks++;
        if ({busy, done, weight_valid, weight_last, ram_enable} !== 5'b0 || weight_data !== 16'h0) begin
            errors++; $display("FAIL mid_reset: got flags %b data %h want 00000 0000",
                {busy, done, weight_valid, weight_last, ram_enable}, weight_data);
        end
        step; step; reset_n = 1;
        for (int k = 0; k < 3; k++) begin
            step; #1;
            checks++;
            if (busy !== 0 || done !== 0) begin
                errors++; $display("FAIL mid_after_%0d: got busy %b done %b want 0 0", k, busy, done);
            end
        end
        step; start = 1; filter_index = 5; #1;
        step; start = 0; #1;
        step; #1;
        checks++;
        if (weight_valid !== 1 || weight_data !== 16'd45) begin
            errors++; $display("FAIL mid_refetch: got v %b %h want 1 002d", weight_valid, weight_data);
        end
        for (int c = 0; c < 20 && !seen_done; c++) begin step; #1; if (done === 1'b1) seen_done = 1; end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL mid_refetch_done: got no done want done"); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        test_reset;
        test_preload;
        test_fetch0;
        test_stall63;
        test_idx_err;
        test_host_during_fetch;
        test_bad_addr_simul;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
